rgmii_tx_serializer: RTL

Downstream neighbour of the TX MAC: consumes the MAC's byte-wide RGMII-side stream (`rgmii_mac_tx_data/dv/er`) and paces it with `rgmii_mac_tx_rdy`. Produces per-cycle rise/fall nibble and control pairs plus a TXC pattern, which feed the output DDR primitives. Supports gigabit DDR mode and 10/100 nibble mode, selected by `mii_select`, all on one 125 MHz clock.

---
 rtl/rgmii_tx_pkg.sv | 20 ++
 rtl/rgmii_tx_clk_div.sv | 44 ++++
 rtl/rgmii_tx_serializer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rgmii_tx_pkg.sv
// Shared types and helpers for the RGMII transmit serializer.
package rgmii_tx_pkg;

  typedef enum logic {
    MODE_GIG = 1'b0,
    MODE_MII = 1'b1
  } tx_mode_e;

  typedef enum logic {
    LOW_NIB  = 1'b0,
    HIGH_NIB = 1'b1
  } nib_state_e;

  localparam int MII_DIV_DEFAULT = 5;

  function automatic logic tx_ctl_fall_f(input logic dv, input logic er);
    return dv ^ er;
  endfunction

endpackage

// File: rtl/rgmii_tx_clk_div.sv
// Nibble-period divider for 10/100 mode: counts 0..MII_DIV-1, flags the
// last cycle of a nibble and produces the TXC level for the current cycle.
module rgmii_tx_clk_div
  import rgmii_tx_pkg::*;
#(
  parameter int MII_DIV = MII_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic nib_end,
  output logic txc_level
);

  localparam int CW = (MII_DIV > 2) ? $clog2(MII_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MII_DIV - 1);
  localparam logic [CW-1:0] TXC_HIGH = CW'((MII_DIV + 1) / 2);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  // Parks at CNT_MAX when not running so the next accept is immediate.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (restart) begin
      div_cnt_d = '0;
    end else if (run && !nib_end) begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= CNT_MAX;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign nib_end   = (div_cnt_q == CNT_MAX);
  assign txc_level = (div_cnt_q < TXC_HIGH);

endmodule

// File: rtl/rgmii_tx_serializer.sv
// Byte stream to RGMII rise/fall nibble pairs; gigabit DDR always, 10/100
// nibble mode only when RGMII_TX_MII_EN is defined.
module rgmii_tx_serializer
  import rgmii_tx_pkg::*;
#(
  parameter int MII_DIV = MII_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mii_select,
  input  logic [7:0] rgmii_mac_tx_data,
  input  logic       rgmii_mac_tx_dv,
  input  logic       rgmii_mac_tx_er,
  output logic       rgmii_mac_tx_rdy,
  output logic [3:0] txd_rise,
  output logic [3:0] txd_fall,
  output logic       tx_ctl_rise,
  output logic       tx_ctl_fall,
  output logic       txc_rise,
  output logic       txc_fall
);

  if (MII_DIV < 2) begin : g_bad_div
    $error("rgmii_tx_serializer: MII_DIV must be at least 2");
  end

  logic       active_q, active_d;
  logic [3:0] txd_rise_q, txd_rise_d;
  logic [3:0] txd_fall_q, txd_fall_d;
  logic       ctl_rise_q, ctl_rise_d;
  logic       ctl_fall_q, ctl_fall_d;
  logic       txc_gig_q, txc_gig_d;
  logic       accept;
  tx_mode_e   mode_q;

`ifdef RGMII_TX_MII_EN
  tx_mode_e   mode_d;
  nib_state_e state_q, state_d;
  logic [3:0] byte_hi_q, byte_hi_d;
  logic       div_run;
  logic       div_restart;
  logic       nib_end;
  logic       div_txc;

  rgmii_tx_clk_div #(
    .MII_DIV (MII_DIV)
  ) u_clk_div (
    .clk       (clk),
    .reset     (reset),
    .run       (div_run),
    .restart   (div_restart),
    .nib_end   (nib_end),
    .txc_level (div_txc)
  );

  assign div_run = (mode_q == MODE_MII);

  // In gigabit mode the divider stays parked at HIGH_NIB/terminal count.
  assign rgmii_mac_tx_rdy = active_q &&
                            ((mode_q == MODE_GIG) || ((state_q == HIGH_NIB) && nib_end));
`else
  logic unused_mii_select;

  assign unused_mii_select = mii_select;
  assign mode_q            = MODE_GIG;
  assign rgmii_mac_tx_rdy  = active_q;
`endif

  assign accept = rgmii_mac_tx_rdy;

  always_comb begin
    active_d   = 1'b1;
    txd_rise_d = txd_rise_q;
    txd_fall_d = txd_fall_q;
    ctl_rise_d = ctl_rise_q;
    ctl_fall_d = ctl_fall_q;
    txc_gig_d  = txc_gig_q;
`ifdef RGMII_TX_MII_EN
    mode_d      = mode_q;
    state_d     = state_q;
    byte_hi_d   = byte_hi_q;
    div_restart = 1'b0;
    if (accept) begin
      mode_d     = mii_select ? MODE_MII : MODE_GIG;
      byte_hi_d  = rgmii_mac_tx_data[7:4];
      ctl_rise_d = rgmii_mac_tx_dv;
      ctl_fall_d = tx_ctl_fall_f(rgmii_mac_tx_dv, rgmii_mac_tx_er);
      if (mii_select) begin
        state_d     = LOW_NIB;
        div_restart = 1'b1;
        txd_rise_d  = rgmii_mac_tx_data[3:0];
        txd_fall_d  = rgmii_mac_tx_data[3:0];
        txc_gig_d   = 1'b0;
      end else begin
        state_d    = HIGH_NIB;
        txd_rise_d = rgmii_mac_tx_data[3:0];
        txd_fall_d = rgmii_mac_tx_data[7:4];
        txc_gig_d  = 1'b1;
      end
    end else if ((mode_q == MODE_MII) && (state_q == LOW_NIB) && nib_end) begin
      state_d     = HIGH_NIB;
      div_restart = 1'b1;
      txd_rise_d  = byte_hi_q;
      txd_fall_d  = byte_hi_q;
    end
`else
    if (accept) begin
      txd_rise_d = rgmii_mac_tx_data[3:0];
      txd_fall_d = rgmii_mac_tx_data[7:4];
      ctl_rise_d = rgmii_mac_tx_dv;
      ctl_fall_d = tx_ctl_fall_f(rgmii_mac_tx_dv, rgmii_mac_tx_er);
      txc_gig_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q   <= 1'b0;
      txd_rise_q <= 4'h0;
      txd_fall_q <= 4'h0;
      ctl_rise_q <= 1'b0;
      ctl_fall_q <= 1'b0;
      txc_gig_q  <= 1'b0;
    end else begin
      active_q   <= active_d;
      txd_rise_q <= txd_rise_d;
      txd_fall_q <= txd_fall_d;
      ctl_rise_q <= ctl_rise_d;
      ctl_fall_q <= ctl_fall_d;
      txc_gig_q  <= txc_gig_d;
    end
  end

`ifdef RGMII_TX_MII_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_GIG;
      state_q   <= HIGH_NIB;
      byte_hi_q <= 4'h0;
    end else begin
      mode_q    <= mode_d;
      state_q   <= state_d;
      byte_hi_q <= byte_hi_d;
    end
  end

  assign txc_rise = (mode_q == MODE_MII) ? div_txc : txc_gig_q;
  assign txc_fall = (mode_q == MODE_MII) ? div_txc : 1'b0;
`else
  assign txc_rise = (mode_q == MODE_GIG) && txc_gig_q;
  assign txc_fall = 1'b0;
`endif

  assign txd_rise    = txd_rise_q;
  assign txd_fall    = txd_fall_q;
  assign tx_ctl_rise = ctl_rise_q;
  assign tx_ctl_fall = ctl_fall_q;

endmodule
